// File: rtl/pwm_pkg.sv
// Shared definitions for the steering controller and the pwm_dir generator:
// owner encoding, position limits and the default frame length.
package pwm_pkg;

    typedef enum logic [1:0] {
        OWN_CENTER = 2'd0,
        OWN_AUTO   = 2'd1,
        OWN_MANUAL = 2'd2
    } owner_t;

    localparam logic [7:0] CMD_CENTER = 8'd150;
    localparam logic [7:0] CMD_MIN    = 8'd115;
    localparam logic [7:0] CMD_MAX    = 8'd185;

    localparam int FRAME_CYCLES_DFLT = 607;
    localparam logic [7:0] IDLE_MAX  = 8'hFF;

    // Signed 9-bit compare so no request value can wrap past the limits.
    function automatic logic [7:0] clamp_cmd(input logic [7:0] val);
        logic signed [8:0] v_s;
        logic signed [8:0] min_s;
        logic signed [8:0] max_s;
        v_s   = $signed({1'b0, val});
        min_s = $signed({1'b0, CMD_MIN});
        max_s = $signed({1'b0, CMD_MAX});
        if (v_s < min_s) begin
            return CMD_MIN;
        end else if (v_s > max_s) begin
            return CMD_MAX;
        end else begin
            return val;
        end
    endfunction

endpackage

// File: rtl/pwm_slew.sv
// Slew limiter: moves current toward target by at most step, never past it.
module pwm_slew
    import pwm_pkg::*;
(
    input  logic [7:0] target,
    input  logic [7:0] current,
    input  logic [7:0] step,
    output logic [7:0] next
);

    logic signed [8:0] diff;
    logic signed [8:0] step_s;

    assign diff   = $signed({1'b0, target}) - $signed({1'b0, current});
    assign step_s = $signed({1'b0, step});

    always_comb begin
        next = target;
        if (diff > step_s) begin
            next = current + step;
        end else if (diff < -step_s) begin
            next = current - step;
        end
    end

endmodule

// File: rtl/pwm_steer_ctrl.sv
// Steering owner arbitration between manual and autonomous requesters, with
// per-frame slew of the registered position fed to pwm_dir.
//
// state      | meaning
// OWN_CENTER | nobody owns steering; target parked at CMD_CENTER
// OWN_AUTO   | autonomous requester owns target; falls back after TIMEOUT_FRAMES idle
// OWN_MANUAL | manual requester owns target; auto blocked; falls back after HOLD_FRAMES idle
module pwm_steer_ctrl
    import pwm_pkg::*;
#(
    parameter int FRAME_CYCLES   = FRAME_CYCLES_DFLT,
    parameter int STEP           = 4,
    parameter int TIMEOUT_FRAMES = 25,
    parameter int HOLD_FRAMES    = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       man_valid,
    input  logic [7:0] man_data,
    output logic       man_ready,
    input  logic       auto_valid,
    input  logic [7:0] auto_data,
    output logic       auto_ready,
    output logic [7:0] cmd_out,
    output logic       frame_tick,
    output logic [1:0] owner
);

    localparam int CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_CYCLES - 1);
    localparam logic [7:0] STEP_C    = 8'(STEP);
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT_FRAMES);
    localparam logic [7:0] HOLD_C    = 8'(HOLD_FRAMES);

    logic [CW-1:0] frame_cnt;
    logic [7:0]    target;
    logic [7:0]    idle;
    owner_t        owner_q;
    logic [7:0]    slew_next;

    logic          man_xfer;
    logic          auto_xfer;
    logic          any_xfer;
    logic [7:0]    xfer_data;
    logic          timeout_hit;
    logic          hold_hit;

    assign man_ready  = rst;
    assign auto_ready = rst && (owner_q != OWN_MANUAL) && !man_valid;

    assign man_xfer  = man_valid && man_ready;
    assign auto_xfer = auto_valid && auto_ready;
    assign any_xfer  = man_xfer || auto_xfer;
    assign xfer_data = man_xfer ? man_data : auto_data;

    assign timeout_hit = (owner_q == OWN_AUTO)   && (idle == TIMEOUT_C);
    assign hold_hit    = (owner_q == OWN_MANUAL) && (idle == HOLD_C);

    assign owner = owner_q;

    pwm_slew u_slew (
        .target  (target),
        .current (cmd_out),
        .step    (STEP_C),
        .next    (slew_next)
    );

    // frame_tick lands on the cycle after the counter's last value, so the
    // position update below happens one cycle later still.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt  <= '0;
            frame_tick <= 1'b0;
            cmd_out    <= CMD_CENTER;
        end else begin
            frame_tick <= (frame_cnt == FRAME_LAST);
            if (frame_cnt == FRAME_LAST) begin
                frame_cnt <= '0;
            end else begin
                frame_cnt <= frame_cnt + CW'(1);
            end
            if (frame_tick) begin
                cmd_out <= slew_next;
            end
        end
    end

    // A transfer always beats a fallback landing in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q <= OWN_CENTER;
            target  <= CMD_CENTER;
            idle    <= '0;
        end else begin
            if (any_xfer) begin
                target <= clamp_cmd(xfer_data);
                idle   <= '0;
            end else if (timeout_hit || hold_hit) begin
                target <= CMD_CENTER;
                idle   <= '0;
            end else if (frame_tick && (idle != IDLE_MAX)) begin
                idle <= idle + 8'd1;
            end

            case (owner_q)
                OWN_CENTER: begin
                    if (man_xfer) begin
                        owner_q <= OWN_MANUAL;
                    end else if (auto_xfer) begin
                        owner_q <= OWN_AUTO;
                    end
                end
                OWN_AUTO: begin
                    if (man_xfer) begin
                        owner_q <= OWN_MANUAL;
                    end else if (!auto_xfer && timeout_hit) begin
                        owner_q <= OWN_CENTER;
                    end
                end
                OWN_MANUAL: begin
                    if (!man_xfer && hold_hit) begin
                        owner_q <= OWN_CENTER;
                    end
                end
                default: begin
                    owner_q <= OWN_CENTER;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_steer_ctrl.sv
// Scoreboard bench for pwm_steer_ctrl: stimulus queues expected frame and
// handshake results, a negedge monitor pops and compares them.
module tb_pwm_steer_ctrl;

    localparam int FRAME = 607;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       man_valid = 1'b0;
    logic [7:0] man_data = 8'd0;
    logic       man_ready;
    logic       auto_valid = 1'b0;
    logic [7:0] auto_data = 8'd0;
    logic       auto_ready;
    logic [7:0] cmd_out;
    logic       frame_tick;
    logic [1:0] owner;

    always #5 clk = ~clk;

    pwm_steer_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .man_valid  (man_valid),
        .man_data   (man_data),
        .man_ready  (man_ready),
        .auto_valid (auto_valid),
        .auto_data  (auto_data),
        .auto_ready (auto_ready),
        .cmd_out    (cmd_out),
        .frame_tick (frame_tick),
        .owner      (owner)
    );

    typedef struct {
        logic [7:0] cmd;
        logic [1:0] own;
    } frame_exp_t;

    typedef struct {
        logic mr;
        logic ar;
    } hs_exp_t;

    frame_exp_t frame_q[$];
    hs_exp_t    hs_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int bad_ar   = 0;
    bit pend     = 1'b0;

    int b_exp[10] = '{154, 158, 162, 166, 170, 174, 178, 182, 185, 185};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: frame results one cycle after each frame_tick, handshakes
    // whenever a requester is presenting data.
    always @(negedge clk) begin : mon
        frame_exp_t fe;
        hs_exp_t    he;
        if (!rst) begin
            cyc  = 0;
            pend = 1'b0;
        end else begin
            cyc++;
            if (pend) begin
                if (frame_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL frame_underflow: got unexpected frame, expected none (t=%0t)", $time);
                end else begin
                    fe = frame_q.pop_front();
                    chk("frame_cmd", 32'(cmd_out), 32'(fe.cmd));
                    chk("frame_owner", 32'(owner), 32'(fe.own));
                end
                pend = 1'b0;
            end
            if (frame_tick) begin
                chk("frame_period", cyc, FRAME);
                cyc  = 0;
                pend = 1'b1;
            end
            if ((man_valid || auto_valid) && (hs_q.size() > 0)) begin
                he = hs_q.pop_front();
                chk("man_ready", 32'(man_ready), 32'(he.mr));
                chk("auto_ready", 32'(auto_ready), 32'(he.ar));
            end
            if (owner == 2'd2 && auto_ready) bad_ar++;
        end
    end

    task automatic wait_tick();
        bit seen = 1'b0;
        for (int i = 0; i < FRAME + 100 && !seen; i++) begin
            @(negedge clk);
            if (frame_tick) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL tick_timeout: got no frame_tick, expected one within %0d cycles", FRAME + 100);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic frame(input int c, input int o);
        frame_q.push_back('{8'(c), 2'(o)});
        wait_tick();
    endtask

    // Valids are raised just after a posedge so ready is sampled before the
    // accepting edge; returns aligned to negedge+1.
    task automatic xfer(input logic mv, input int md, input logic av, input int ad,
                        input logic emr, input logic ear);
        @(posedge clk);
        #1;
        hs_q.push_back('{emr, ear});
        man_valid  = mv;
        man_data   = 8'(md);
        auto_valid = av;
        auto_data  = 8'(ad);
        @(posedge clk);
        #1;
        man_valid  = 1'b0;
        auto_valid = 1'b0;
        @(negedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cmd", 32'(cmd_out), 150);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_tick", 32'(frame_tick), 0);
        chk("rst_man_ready", 32'(man_ready), 0);
        chk("rst_auto_ready", 32'(auto_ready), 0);
        @(negedge clk);
        #1;
        rst = 1'b1;

        // idle after reset
        frame(150, 0);
        frame(150, 0);

        // auto 200 clamps to 185
        xfer(1'b0, 0, 1'b1, 200, 1'b1, 1'b1);
        for (int k = 0; k < 10; k++) frame(b_exp[k], 1);

        // simultaneous requests: manual wins
        xfer(1'b1, 120, 1'b1, 180, 1'b1, 1'b0);
        auto_valid = 1'b1;
        auto_data  = 8'd180;
        chk("auto_ready_blocked", 32'(auto_ready), 0);
        for (int k = 1; k <= 50; k++) begin
            frame((k <= 16) ? 185 - 4 * k : 120, 2);
            if (k == 3) begin
                chk("auto_ready_held", 32'(auto_ready), 0);
                auto_valid = 1'b0;
            end
        end
        for (int k = 51; k <= 57; k++) frame(120 + 4 * (k - 50), 0);
        frame(150, 0);

        // auto 170 then timeout back to center
        xfer(1'b0, 0, 1'b1, 170, 1'b1, 1'b1);
        for (int k = 1; k <= 25; k++) frame((k <= 5) ? 150 + 4 * k : 170, 1);
        for (int k = 26; k <= 30; k++) frame(170 - 4 * (k - 25), 0);

        // mid-frame reset with cmd_out at 170
        xfer(1'b0, 0, 1'b1, 170, 1'b1, 1'b1);
        for (int k = 1; k <= 5; k++) frame(150 + 4 * k, 1);
        repeat (298) @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_cmd", 32'(cmd_out), 150);
        chk("midrst_owner", 32'(owner), 0);
        chk("midrst_man_ready", 32'(man_ready), 0);
        chk("midrst_auto_ready", 32'(auto_ready), 0);
        chk("midrst_tick", 32'(frame_tick), 0);
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b1;
        frame(150, 0);

        chk("auto_ready_in_manual", bad_ar, 0);
        chk("frame_q_drain", frame_q.size(), 0);
        chk("hs_q_drain", hs_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_steer_ctrl.md
PWM_STEER_CTRL -- requirements
Module: pwm_steer_ctrl

Interface
REQ-001 Parameter FRAME_CYCLES, default 607: clock cycles per steering frame, equal to the pwm_dir period.
REQ-002 Parameter STEP, default 4: max cmd_out change per frame.
REQ-003 Parameter TIMEOUT_FRAMES, default 25: idle frames before AUTO falls back to CENTER.
REQ-004 Parameter HOLD_FRAMES, default 50: idle frames before MANUAL falls back to CENTER.
REQ-005 Constants CMD_CENTER=150, CMD_MIN=115, CMD_MAX=185 (8-bit).
REQ-006 One clock; reset is asynchronous and active-low; ports are named clk and rst.
REQ-007 clk  in  1  system clock.
REQ-008 rst  in  1  asynchronous active-low reset.
REQ-009 man_valid  in  1  manual requester has a position.
REQ-010 man_data  in  8  manual position.
REQ-011 man_ready  out  1  manual transfer accepted this cycle.
REQ-012 auto_valid  in  1  autonomous requester has a position.
REQ-013 auto_data  in  8  autonomous position.
REQ-014 auto_ready  out  1  autonomous transfer accepted this cycle.
REQ-015 cmd_out  out  8  registered position to pwm_dir data_in.
REQ-016 frame_tick  out  1  registered one-cycle strobe at frame end.
REQ-017 owner  out  2  current state: 0 CENTER, 1 AUTO, 2 MANUAL.

Function
REQ-018 The frame counter SHALL count 0..FRAME_CYCLES-1 and wrap; frame_tick SHALL be high for exactly the cycle after the counter reaches FRAME_CYCLES-1.
REQ-019 man_ready SHALL be 1 whenever rst is deasserted; auto_ready SHALL be (owner != MANUAL) && !man_valid.
REQ-020 A transfer SHALL occur when valid && ready; manual wins on simultaneous valid.
REQ-021 An accepted value SHALL be clamped to CMD_MIN..CMD_MAX and written to the target register on the next clock edge.
REQ-022 cmd_out SHALL change only on the cycle after frame_tick, moving toward target by min(STEP, |target-cmd_out|); no overshoot, no change when equal.
REQ-023 A transfer on the frame_tick cycle SHALL update target, with slew using the old target.
REQ-024 The idle counter SHALL clear on any transfer, increment on each frame_tick otherwise, and saturate at 255.
REQ-025 FSM transitions: CENTER->MANUAL on manual transfer; CENTER->AUTO on auto transfer; AUTO->MANUAL on manual transfer; AUTO->CENTER when idle == TIMEOUT_FRAMES; MANUAL->CENTER when idle == HOLD_FRAMES.
REQ-026 On entry to CENTER, target SHALL be set to CMD_CENTER and the idle counter cleared.
REQ-027 A transfer in the same cycle as a timeout SHALL take precedence; no fallback occurs.
REQ-028 All arithmetic SHALL use 9-bit signed differences; no 8-bit wrap.

Reset
REQ-029 While rst is low: cmd_out=150, target=150, owner=CENTER, frame counter=0, idle=0, frame_tick=0, man_ready=0, auto_ready=0.
REQ-030 Mid-frame reset SHALL abort the frame; the first frame_tick after release SHALL occur FRAME_CYCLES cycles later.

Structure
REQ-031 Package pwm_pkg SHALL hold the owner enum, CMD_CENTER/MIN/MAX and the FRAME_CYCLES default, shared with pwm_dir.
REQ-032 The slew limiter SHALL be a sub-module pwm_slew (target, current, step -> next).

Verification
REQ-033 Reset release, no requests -> cmd_out=150, owner=0, frame_tick every 607 cycles.
REQ-034 Auto transfer of 200 -> target 185; cmd_out steps 154, 158 ... 182, 185 at successive frames; owner=1.
REQ-035 man_valid and auto_valid both high, data 120/180 -> man_ready=1, auto_ready=0, target 120, owner=2.
REQ-036 In MANUAL, auto_valid held high -> auto_ready stays 0; after 50 idle frames -> owner=0, cmd_out slews back to 150.
REQ-037 Auto transfer of 170, then no traffic for 25 frames -> owner=0, target 150.
REQ-038 rst asserted at frame cycle 300 with cmd_out=170 -> cmd_out=150 at once; next frame_tick 607 cycles after release.
